// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data memory arbiter: FSM states, port ids and access op codes.
package dmem_arb_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ      = 3'd2;
  localparam logic [2:0] ST_READ_WAIT = 3'd3;
  localparam logic [2:0] ST_RMW_WAIT  = 3'd4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WRITE     = ST_WRITE,
    S_READ      = ST_READ,
    S_READ_WAIT = ST_READ_WAIT,
    S_RMW_WAIT  = ST_RMW_WAIT
  } state_e;

  typedef enum logic [1:0] {
    OP_RD_BYTE = 2'd0,
    OP_RD_WORD = 2'd1,
    OP_WR_BYTE = 2'd2,
    OP_WR_WORD = 2'd3
  } op_e;

  function automatic op_e op_of(input logic wr, input logic word);
    case ({wr, word})
      2'b00:   return OP_RD_BYTE;
      2'b01:   return OP_RD_WORD;
      2'b10:   return OP_WR_BYTE;
      default: return OP_WR_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Fixed cpu priority with a starvation guard; winner is combinational, count updates at pick strobes.
// Aux is forced through after STARVE_LIMIT cpu grants made while it was waiting.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic aux_req,
  input  logic pick,
  output logic winner
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          aux_win;

  assign aux_win = aux_req && (!cpu_req || (starve_cnt == LIMIT));
  assign winner  = aux_win ? PORT_AUX : PORT_CPU;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!aux_req || (pick && aux_win)) begin
      starve_cnt <= '0;
    end else if (pick && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data memory between cpu and aux; word write 2 cycles, read 3 (Rvalid on 3rd), byte write 4.
// Losing requester holds its command until its Gnt pulse; cpuStall flags a waiting cpu.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpuReq,
  input  logic          cpuWr,
  input  logic          cpuWord,
  input  logic [AW-1:0] cpuAddr,
  input  logic [15:0]   cpuWdata,
  output logic          cpuGnt,
  output logic          cpuRvalid,
  output logic [15:0]   cpuRdata,
  output logic          cpuErr,
  output logic          cpuStall,
  input  logic          auxReq,
  input  logic          auxWr,
  input  logic          auxWord,
  input  logic [AW-1:0] auxAddr,
  input  logic [15:0]   auxWdata,
  output logic          auxGnt,
  output logic          auxRvalid,
  output logic [15:0]   auxRdata,
  output logic          auxErr,
  output logic          memWrEnable,
  output logic          memRdEnable,
  output logic [AW-1:0] memAddress,
  output logic [15:0]   memIn,
  output logic          memNumberOfByte,
  input  logic [15:0]   memOut
);

  state_e        state;
  op_e           cmd_op;
  logic          cmd_port;
  logic [7:0]    cmd_wbyte;
  logic          pick;
  logic          winner;
  logic          sel_wr;
  logic          sel_word;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;
  op_e           sel_op;
  logic [AW:0]   sel_last;
  logic          sel_err;
  logic [15:0]   rdata_next;

  assign pick     = (state == S_IDLE) && (cpuReq || auxReq);
  assign cpuStall = cpuReq & ~cpuGnt;

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpuReq),
    .aux_req (auxReq),
    .pick    (pick),
    .winner  (winner)
  );

  always_comb begin
    sel_wr    = cpuWr;
    sel_word  = cpuWord;
    sel_addr  = cpuAddr;
    sel_wdata = cpuWdata;
    if (winner == PORT_AUX) begin
      sel_wr    = auxWr;
      sel_word  = auxWord;
      sel_addr  = auxAddr;
      sel_wdata = auxWdata;
    end
  end

  assign sel_op = op_of(sel_wr, sel_word);

  // Highest byte touched: byte writes fetch addr+1 for the merge, so they need it in range too.
  assign sel_last   = {1'b0, sel_addr} + {{AW{1'b0}}, (sel_wr | sel_word)};
  assign sel_err    = sel_last >= (AW+1)'(MEM_BYTES);
  assign rdata_next = (cmd_op == OP_RD_WORD) ? memOut : {8'h00, memOut[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cmd_op          <= OP_RD_BYTE;
      cmd_port        <= PORT_CPU;
      cmd_wbyte       <= '0;
      cpuGnt          <= 1'b0;
      auxGnt          <= 1'b0;
      cpuErr          <= 1'b0;
      auxErr          <= 1'b0;
      cpuRvalid       <= 1'b0;
      auxRvalid       <= 1'b0;
      cpuRdata        <= '0;
      auxRdata        <= '0;
      memWrEnable     <= 1'b0;
      memRdEnable     <= 1'b0;
      memAddress      <= '0;
      memIn           <= '0;
      memNumberOfByte <= 1'b0;
    end else begin
      cpuGnt      <= 1'b0;
      auxGnt      <= 1'b0;
      cpuErr      <= 1'b0;
      auxErr      <= 1'b0;
      cpuRvalid   <= 1'b0;
      auxRvalid   <= 1'b0;
      memWrEnable <= 1'b0;
      memRdEnable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick) begin
            cmd_port   <= winner;
            cmd_op     <= sel_op;
            cmd_wbyte  <= sel_wdata[7:0];
            memAddress <= sel_addr;
            if (sel_err) begin
              // Rejected access reuses the WRITE slot with no enables raised.
              state <= S_WRITE;
              if (winner == PORT_AUX) begin
                auxGnt <= 1'b1;
                auxErr <= 1'b1;
              end else begin
                cpuGnt <= 1'b1;
                cpuErr <= 1'b1;
              end
            end else if (sel_op == OP_WR_WORD) begin
              state           <= S_WRITE;
              memWrEnable     <= 1'b1;
              memIn           <= sel_wdata;
              memNumberOfByte <= 1'b1;
              if (winner == PORT_AUX) auxGnt <= 1'b1;
              else                    cpuGnt <= 1'b1;
            end else if (sel_op == OP_WR_BYTE) begin
              state           <= S_READ;
              memRdEnable     <= 1'b1;
              memNumberOfByte <= 1'b1;
            end else begin
              state           <= S_READ;
              memRdEnable     <= 1'b1;
              memNumberOfByte <= sel_word;
              if (winner == PORT_AUX) auxGnt <= 1'b1;
              else                    cpuGnt <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ: begin
          state <= (cmd_op == OP_WR_BYTE) ? S_RMW_WAIT : S_READ_WAIT;
        end
        S_READ_WAIT: begin
          state <= S_IDLE;
          if (cmd_port == PORT_AUX) begin
            auxRdata  <= rdata_next;
            auxRvalid <= 1'b1;
          end else begin
            cpuRdata  <= rdata_next;
            cpuRvalid <= 1'b1;
          end
        end
        S_RMW_WAIT: begin
          // Memory always writes two bytes, so the fetched upper byte is written back unchanged.
          state           <= S_WRITE;
          memWrEnable     <= 1'b1;
          memIn           <= {memOut[15:8], cmd_wbyte};
          memNumberOfByte <= 1'b1;
          if (cmd_port == PORT_AUX) auxGnt <= 1'b1;
          else                      cpuGnt <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized two-port traffic against a byte-array memory model, plus directed timing and corner cases.
module tb_data_mem_arbiter;

  localparam int MEMB = 1024;

  typedef struct {
    int          p;
    int          c;
    logic [15:0] d;
  } exp_rv_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_s   [2];
  logic        wr_s    [2];
  logic        word_s  [2];
  logic [15:0] addr_s  [2];
  logic [15:0] wdata_s [2];

  logic        cpuGnt, auxGnt, cpuRvalid, auxRvalid, cpuErr, auxErr, cpuStall;
  logic [15:0] cpuRdata, auxRdata;
  logic        memWrEnable, memRdEnable, memNumberOfByte;
  logic [15:0] memAddress, memIn, memOut;
  logic [1:0]  gnt_b, err_b;

  logic [7:0]  ref_mem [MEMB];
  logic [7:0]  phys    [MEMB];
  logic        mem_load = 1'b0;
  logic        mon_en = 1'b0;
  logic        rec = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_rv_cyc = 0;
  int          ma;
  exp_rv_t     rvq[$];
  int          gseq[$];
  logic [1:0]  mon_erv;
  logic [15:0] mon_ed;

  data_mem_arbiter #(.AW(16), .MEM_BYTES(MEMB), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuReq(req_s[0]), .cpuWr(wr_s[0]), .cpuWord(word_s[0]), .cpuAddr(addr_s[0]), .cpuWdata(wdata_s[0]),
    .cpuGnt(cpuGnt), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata), .cpuErr(cpuErr), .cpuStall(cpuStall),
    .auxReq(req_s[1]), .auxWr(wr_s[1]), .auxWord(word_s[1]), .auxAddr(addr_s[1]), .auxWdata(wdata_s[1]),
    .auxGnt(auxGnt), .auxRvalid(auxRvalid), .auxRdata(auxRdata), .auxErr(auxErr),
    .memWrEnable(memWrEnable), .memRdEnable(memRdEnable), .memAddress(memAddress), .memIn(memIn),
    .memNumberOfByte(memNumberOfByte), .memOut(memOut)
  );

  assign gnt_b = {auxGnt, cpuGnt};
  assign err_b = {auxErr, cpuErr};
  assign ma    = int'(memAddress);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory behind the arbiter: registered read, two-byte write when memNumberOfByte is set.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEMB; i++) phys[i] <= ref_mem[i];
    end else begin
      if (memWrEnable && ma < MEMB) begin
        phys[ma] <= memIn[7:0];
        if (memNumberOfByte && ma + 1 < MEMB) phys[ma+1] <= memIn[15:8];
      end
      if (memRdEnable && ma < MEMB)
        memOut <= (memNumberOfByte && ma + 1 < MEMB) ? {phys[ma+1], phys[ma]} : {8'h00, phys[ma]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle invariants and read-response checking.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_erv = '0;
      mon_ed  = '0;
      if (rvq.size() > 0 && rvq[0].c == cyc) begin
        mon_erv[rvq[0].p] = 1'b1;
        mon_ed = rvq[0].d;
      end
      chk("rvalid_cpu", cpuRvalid, mon_erv[0]);
      chk("rvalid_aux", auxRvalid, mon_erv[1]);
      if (mon_erv != 2'b00) begin
        chk("rdata", mon_erv[1] ? auxRdata : cpuRdata, mon_ed);
        last_rv_cyc = cyc;
        void'(rvq.pop_front());
      end
      chk("two_gnt", cpuGnt & auxGnt, 0);
      chk("stall", cpuStall, req_s[0] & ~cpuGnt);
      chk("both_en", memWrEnable & memRdEnable, 0);
      if (rec) begin
        if (cpuGnt) gseq.push_back(0);
        if (auxGnt) gseq.push_back(1);
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    req_s[p]   = 1'b1;
    wr_s[p]    = w;
    word_s[p]  = wd;
    addr_s[p]  = a;
    wdata_s[p] = d;
  endtask

  // Applies a granted command to the reference byte array and checks the memory-side command.
  task automatic apply(input int p);
    int          a;
    logic        e;
    logic [15:0] nd;
    a = int'(addr_s[p]);
    e = (wr_s[p] || word_s[p]) ? (a + 1 >= MEMB) : (a >= MEMB);
    chk("err", err_b[p], e);
    if (e) begin
      chk("err_no_enable", {memWrEnable, memRdEnable}, 0);
    end else if (wr_s[p]) begin
      nd = word_s[p] ? wdata_s[p] : {ref_mem[a+1], wdata_s[p][7:0]};
      chk("wr_enable", memWrEnable, 1);
      chk("wr_addr", memAddress, a);
      chk("wr_data", memIn, nd);
      ref_mem[a] = nd[7:0];
      if (word_s[p]) ref_mem[a+1] = nd[15:8];
    end else begin
      chk("rd_enable", memRdEnable, 1);
      chk("rd_addr", memAddress, a);
      chk("rd_nbytes", memNumberOfByte, word_s[p]);
      rvq.push_back('{p: p, c: cyc + 2,
                      d: word_s[p] ? {ref_mem[a+1], ref_mem[a]} : {8'h00, ref_mem[a]}});
    end
  endtask

  task automatic await_gnt(input int p, output int gc);
    logic got;
    got = 1'b0;
    gc  = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (gnt_b[p]) begin
        got = 1'b1;
        gc  = cyc;
      end else if (p == 0) begin
        chk("stall_while_waiting", cpuStall, 1);
      end
    end
    chk("gnt_seen", got, 1);
    if (got) apply(p);
  endtask

  task automatic op(input int p, input logic w, input logic wd, input logic [15:0] a,
                    input logic [15:0] d, input bit keep, output int gc);
    issue(p, w, wd, a, d);
    await_gnt(p, gc);
    if (!keep) req_s[p] = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 19))
      0:       return 16'd1022;
      1:       return 16'd1023;
      2:       return 16'd1024;
      3:       return 16'hFFFF;
      default: return 16'($urandom_range(0, MEMB - 1));
    endcase
  endfunction

  task automatic run_rand(input int p, input int n);
    int gc;
    for (int i = 0; i < n; i++) begin
      op(p, 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom), 1'b0, gc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic run_hold(input int p, input int n);
    int gc;
    for (int i = 0; i < n; i++)
      op(p, 1'b1, 1'b1, 16'($urandom_range(0, MEMB - 2)), 16'($urandom), i != n - 1, gc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int gc, t0;
    for (int p = 0; p < 2; p++) begin
      req_s[p] = 1'b0; wr_s[p] = 1'b0; word_s[p] = 1'b0; addr_s[p] = '0; wdata_s[p] = '0;
    end
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'($urandom);
    mem_load = 1'b1;
    repeat (2) @(negedge clk);
    mem_load = 1'b0;

    chk("rst_gnt", {cpuGnt, auxGnt}, 0);
    chk("rst_rvalid", {cpuRvalid, auxRvalid}, 0);
    chk("rst_err", {cpuErr, auxErr}, 0);
    chk("rst_mem_en", {memWrEnable, memRdEnable}, 0);
    chk("rst_rdata", {cpuRdata, auxRdata}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Word write then word read, back to back.
    t0 = cyc;
    op(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, gc);
    chk("wr_gnt_cycle", gc - t0, 1);
    op(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, gc);
    chk("rd_gnt_cycle", gc - t0, 3);
    repeat (3) @(negedge clk);
    chk("rvalid_cycle", last_rv_cyc - t0, 5);
    chk("rd_word_beef", cpuRdata, 16'hBEEF);

    // Byte read, byte write (read-modify-write), word read back.
    op(0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0, gc);
    repeat (3) @(negedge clk);
    chk("rd_byte_be", cpuRdata, 16'h00BE);
    t0 = cyc;
    op(0, 1'b1, 1'b0, 16'h0010, 16'h3412, 1'b0, gc);
    chk("bw_gnt_cycle", gc - t0, 3);
    op(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, gc);
    repeat (3) @(negedge clk);
    chk("rd_word_be12", cpuRdata, 16'hBE12);

    // Both requesters held continuously: aux forced through after four cpu grants.
    gseq.delete();
    rec = 1'b1;
    fork
      run_hold(0, 8);
      run_hold(1, 2);
    join
    rec = 1'b0;
    chk("starve_len", gseq.size(), 10);
    for (int i = 0; i < 10; i++) chk("starve_seq", gseq[i], (i % 5) == 4);

    // Out-of-range aux word read at the last byte.
    repeat (2) @(negedge clk);
    t0 = cyc;
    op(1, 1'b0, 1'b1, 16'h03FF, 16'h0000, 1'b0, gc);
    chk("err_gnt_cycle", gc - t0, 1);
    chk("err_aux_flag", auxErr, 1);
    repeat (4) @(negedge clk);

    // cpu request arriving while an aux read is in flight.
    op(1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, gc);
    t0 = gc;
    op(0, 1'b0, 1'b1, 16'h0022, 16'h0000, 1'b0, gc);
    chk("stall_gnt_cycle", gc - t0, 3);
    repeat (4) @(negedge clk);

    // Reset during READ_WAIT with a further cpu read pending.
    op(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1'b1, gc);
    issue(0, 1'b0, 1'b1, 16'h0032, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    rvq.delete();
    #1;
    chk("rst_mid_en", {memWrEnable, memRdEnable}, 0);
    chk("rst_mid_rdata", cpuRdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    await_gnt(0, gc);
    req_s[0] = 1'b0;
    chk("rst_regrant_cycle", gc - t0, 1);
    repeat (4) @(negedge clk);

    fork
      run_rand(0, 150);
      run_rand(1, 150);
    join
    repeat (8) @(negedge clk);
    chk("rvq_drained", rvq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
